custom_reg_master: RTL and testbench
====================================

CUSTOM_REG_MASTER -- requirements
Module: custom_reg_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, power of two, 2..32: depth of the posted-write queue.
REQ-002 Parameter IDLE_ADDR, default 8'hFF: bus address driven when no access is in progress (register $1FE, no-op).
REQ-003 clk  in  1  28MHz system clock; the only clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 clk7_en  in  1  7MHz clock enable; all bus-side state advances only when high.
REQ-006 bus_grant  in  1  sampled on clk7_en; high = next 7MHz slot is free for this master (no DMA slot).
REQ-007 req_valid  in  1  host request present.
REQ-008 req_ready  out  1  host request accepted when req_valid & req_ready on a clk edge.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  8  register address bits [8:1].
REQ-011 req_data  in  16  write data (ignored for reads).
REQ-012 rsp_valid  out  1  one-clk pulse: read data available.
REQ-013 rsp_data  out  16  read data, held until next read completes.
REQ-014 reg_address_out  out  8  register bus address [8:1] to the video chips.
REQ-015 data_out  out  16  register bus write data.
REQ-016 data_in  in  16  register bus read data (OR of chip outputs, combinational from address).

Function
REQ-017 Writes are posted: each accepted write enters the FIFO in the accepting cycle; req_ready for a write = FIFO not full.
REQ-018 A read is accepted only when FIFO empty and FSM in IDLE with no read outstanding; reads are never reordered ahead of earlier writes.
REQ-019 FSM states: IDLE, WRITE, READ, CAPTURE; transitions evaluated only on clk7_en.
REQ-020 IDLE -> WRITE when FIFO non-empty and bus_grant; FIFO head popped, reg_address_out/data_out loaded with it.
REQ-021 WRITE holds the address/data for exactly one clk7_en period, then -> WRITE again (next entry) if FIFO non-empty and bus_grant, else IDLE.
REQ-022 IDLE -> READ when a read is pending and bus_grant; reg_address_out = read address, data_out = 0.
REQ-023 READ -> CAPTURE on next clk7_en: rsp_data <= data_in sampled at that edge; CAPTURE lasts zero extra bus slots: rsp_valid pulses for the single clk following that edge; state -> IDLE.
REQ-024 Whenever state is IDLE, reg_address_out = IDLE_ADDR and data_out = 16'h0000.
REQ-025 bus_grant low while FIFO non-empty: no bus access, state IDLE, FIFO contents preserved.
REQ-026 Simultaneous push (host) and pop (bus) in one clk: both occur, count unchanged; allowed when full (pop frees the slot same cycle only if req_ready defined combinationally from pop — it SHALL NOT be; req_ready uses registered full flag).
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1; full = count==FIFO_DEPTH, empty = count==0.
REQ-028 Writes to the same address are delivered in acceptance order, one per slot, never merged.
REQ-029 Latency: write accepted in an empty FIFO with bus_grant continuously high appears on the bus at the first clk7_en edge after acceptance.

Reset
REQ-030 reset_n low: FSM IDLE, FIFO empty, pointers 0, reg_address_out = IDLE_ADDR, data_out = 0, rsp_valid = 0, rsp_data = 0, req_ready = 0 for the first clk after release then 1.
REQ-031 Reset mid-access aborts immediately (asynchronously); queued writes and an outstanding read are discarded, no rsp_valid issued.

Structure
REQ-032 Shared package holds IDLE_ADDR default, FSM state encoding, and register address constants (BPLCON0..4, DIWSTRT, DIWSTOP, DIWHIGH, DENISEID, BPL1DAT).
REQ-033 One sub-module: reg_write_fifo (synchronous FIFO, width 24 = addr+data, depth FIFO_DEPTH, registered full/empty).
REQ-034 All outputs driven from registers; no combinational path from data_in to any output.

Verification
REQ-035 Reset: assert reset_n low mid-WRITE with 3 entries queued -> reg_address_out = 8'hFF, data_out = 0, FIFO empty, no further bus writes.
REQ-036 Single write BPLCON0 ($100) = 16'h9200, bus_grant=1 -> reg_address_out = 8'h80, data_out = 16'h9200 for exactly one clk7_en period, then 8'hFF.
REQ-037 Fill: 9 writes back-to-back with bus_grant=0, FIFO_DEPTH=8 -> req_ready low after 8th; raise bus_grant -> 8 writes in order on 8 consecutive slots; 9th accepted after first pop.
REQ-038 Grant gaps: 4 queued writes, bus_grant pattern 1,0,1,1,0,1 -> writes appear only in granted slots, order preserved, 8'hFF in gaps.
REQ-039 Read ordering: write $100 then read DENISEID ($07C) -> read not accepted until write issued; bus shows 8'h3E; data_in=16'hFFFC -> rsp_valid one clk, rsp_data = 16'hFFFC.
REQ-040 Simultaneous push/pop at count 4 -> count stays 4, data order intact across pointer wrap after 20 mixed operations.

Source files
------------

// File: rtl/custom_reg_master_pkg.sv
// Shared definitions for the video-chip register bus master: idle address,
// FSM encoding and the register indices (byte address bits [8:1]).
package custom_reg_master_pkg;

  localparam logic [7:0] IDLE_ADDR_DEFAULT = 8'hFF;
  localparam int         FIFO_WIDTH        = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  localparam logic [7:0] REG_BPLCON0  = 8'h80;
  localparam logic [7:0] REG_BPLCON1  = 8'h81;
  localparam logic [7:0] REG_BPLCON2  = 8'h82;
  localparam logic [7:0] REG_BPLCON3  = 8'h83;
  localparam logic [7:0] REG_BPLCON4  = 8'h86;
  localparam logic [7:0] REG_DIWSTRT  = 8'h47;
  localparam logic [7:0] REG_DIWSTOP  = 8'h48;
  localparam logic [7:0] REG_DIWHIGH  = 8'hF2;
  localparam logic [7:0] REG_DENISEID = 8'h3E;
  localparam logic [7:0] REG_BPL1DAT  = 8'h88;

endpackage

// File: rtl/custom_reg_master_fifo.sv
// Posted-write queue: synchronous FIFO of {addr, data} entries with
// registered full/empty flags.
module reg_write_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             doPush;
  logic             doPop;

  assign doPush  = push_i & ~full_q;
  assign doPop   = pop_i & ~empty_q;
  assign count_d = count_q + CW'(doPush) - CW'(doPop);
  assign data_o  = mem_q[rdPtr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/custom_reg_master.sv
// Register-bus master for the video chips: posts host writes through a queue
// and issues them, or a single read, on granted 7MHz bus slots.
module custom_reg_master
  import custom_reg_master_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] IDLE_ADDR  = IDLE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        bus_grant,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [7:0]  reg_address_out,
  output logic [15:0] data_out,
  input  logic [15:0] data_in
);

  state_e                state_q, state_d;
  logic [7:0]            addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  rspValid_q, rspValid_d;
  logic [15:0]           rspData_q, rspData_d;
  logic                  rdPending_q, rdPending_d;
  logic [7:0]            rdAddr_q, rdAddr_d;
  logic                  readyEn_q;

  logic                  fifoPush;
  logic                  fifoPop;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [FIFO_WIDTH-1:0] fifoHead;
  logic                  wrReady;
  logic                  rdReady;
  logic                  rdAccept;

  // Reads wait for every earlier write to leave the bus, so they never overtake.
  assign wrReady   = readyEn_q & ~fifoFull;
  assign rdReady   = readyEn_q & fifoEmpty & (state_q == ST_IDLE) & ~rdPending_q;
  assign req_ready = req_we ? wrReady : rdReady;
  assign fifoPush  = req_valid & req_we & wrReady;
  assign rdAccept  = req_valid & ~req_we & rdReady;

  reg_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifoPush),
    .data_i  ({req_addr, req_data}),
    .pop_i   (fifoPop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rspValid_d  = 1'b0;
    rspData_d   = rspData_q;
    rdPending_d = rdPending_q;
    rdAddr_d    = rdAddr_q;
    fifoPop     = 1'b0;

    if (rdAccept) begin
      rdPending_d = 1'b1;
      rdAddr_d    = req_addr;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (clk7_en && bus_grant) begin
          if (rdPending_q) begin
            state_d     = ST_READ;
            addr_d      = rdAddr_q;
            data_d      = 16'h0000;
            rdPending_d = 1'b0;
          end else if (!fifoEmpty) begin
            state_d = ST_WRITE;
            fifoPop = 1'b1;
            addr_d  = fifoHead[23:16];
            data_d  = fifoHead[15:0];
          end
        end
      end
      ST_WRITE: begin
        if (clk7_en) begin
          if (!fifoEmpty && bus_grant) begin
            fifoPop = 1'b1;
            addr_d  = fifoHead[23:16];
            data_d  = fifoHead[15:0];
          end else begin
            state_d = ST_IDLE;
            addr_d  = IDLE_ADDR;
            data_d  = 16'h0000;
          end
        end
      end
      ST_READ: begin
        if (clk7_en) begin
          state_d    = ST_CAPTURE;
          rspData_d  = data_in;
          rspValid_d = 1'b1;
          addr_d     = IDLE_ADDR;
          data_d     = 16'h0000;
        end
      end
      // Capture occupies no bus slot: one clk for the response pulse, then idle.
      ST_CAPTURE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        addr_d  = IDLE_ADDR;
        data_d  = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= IDLE_ADDR;
      data_q      <= 16'h0000;
      rspValid_q  <= 1'b0;
      rspData_q   <= 16'h0000;
      rdPending_q <= 1'b0;
      rdAddr_q    <= 8'h00;
      readyEn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rspValid_q  <= rspValid_d;
      rspData_q   <= rspData_d;
      rdPending_q <= rdPending_d;
      rdAddr_q    <= rdAddr_d;
      readyEn_q   <= 1'b1;
    end
  end

  assign reg_address_out = addr_q;
  assign data_out        = data_q;
  assign rsp_valid       = rspValid_q;
  assign rsp_data        = rspData_q;

endmodule

// File: tb/tb_custom_reg_master.sv
// Scoreboard bench for custom_reg_master: expected bus slots and read
// responses are queued at acceptance and popped when the DUT produces them.
module tb_custom_reg_master;
  import custom_reg_master_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        clk7_en;
  logic        bus_grant;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [7:0]  reg_address_out;
  logic [15:0] data_out;
  logic [15:0] data_in;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] busExp [$];
  logic [15:0] rspExp [$];
  int          ph;
  logic        en;
  logic        prevRsp;

  custom_reg_master #(.FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clk7_en         (clk7_en),
    .bus_grant       (bus_grant),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .reg_address_out (reg_address_out),
    .data_out        (data_out),
    .data_in         (data_in)
  );

  // Video chip model: read data is a combinational function of the bus address.
  function automatic logic [15:0] chipModel(input logic [7:0] a);
    if (a == REG_DENISEID) return 16'hFFFC;
    return {a, ~a};
  endfunction

  assign data_in = chipModel(reg_address_out);

  initial begin
    clk = 1'b0;
    forever #18 clk = ~clk;
  end

  initial begin
    clk7_en = 1'b0;
    ph      = 0;
    forever begin
      @(posedge clk);
      #3;
      ph      = (ph + 1) % 4;
      clk7_en = (ph == 3);
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    if (obs !== expd) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expd);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [15:0] data);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    #1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(we ? "wr_accept" : "rd_accept", req_ready, 1'b1);
    if (req_ready) begin
      @(posedge clk);
      if (we) busExp.push_back({addr, data});
      else begin
        busExp.push_back({addr, 16'h0000});
        rspExp.push_back(chipModel(addr));
      end
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitEn();
    int n;
    n = 0;
    while (!clk7_en && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((busExp.size() != 0 || rspExp.size() != 0) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain_bus", busExp.size(), 0);
    checkOutput("drain_rsp", rspExp.size(), 0);
  endtask

  // Bus and response monitor, sampling on the falling edge.
  initial begin
    logic [23:0] e;
    logic [15:0] r;
    prevRsp = 1'b0;
    forever begin
      @(posedge clk);
      en = clk7_en;
      @(negedge clk);
      if (reset_n) begin
        if (en && reg_address_out != 8'hFF) begin
          if (busExp.size() == 0) checkOutput("bus_unexpected", busExp.size(), 1);
          else begin
            e = busExp.pop_front();
            checkOutput("bus_slot", {reg_address_out, data_out}, e);
          end
        end
        if (en && reg_address_out == 8'hFF) checkOutput("idle_data", data_out, 16'h0000);
        if (rsp_valid) begin
          checkOutput("rsp_pulse", prevRsp, 1'b0);
          if (rspExp.size() == 0) checkOutput("rsp_unexpected", rspExp.size(), 1);
          else begin
            r = rspExp.pop_front();
            checkOutput("rsp_data", rsp_data, r);
          end
        end
        prevRsp = rsp_valid;
      end else begin
        prevRsp = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0]  fillAddr [9];
    logic [0:0]  pat [6];
    int          k;
    int          n;
    int          expCount;
    logic        g;
    logic        p;
    logic        acc;

    fillAddr = '{REG_BPLCON0, REG_BPLCON1, REG_BPLCON2, REG_BPLCON3, REG_BPLCON4,
                 REG_DIWSTRT, REG_DIWSTOP, REG_DIWHIGH, REG_BPL1DAT};
    pat      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset_n   = 1'b0;
    bus_grant = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_addr  = 8'h00;
    req_data  = 16'h0000;

    // Reset state and the one-clk ready hold-off after release
    repeat (3) @(negedge clk);
    checkOutput("rst_addr", reg_address_out, 8'hFF);
    checkOutput("rst_data", data_out, 16'h0000);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_data", rsp_data, 16'h0000);
    checkOutput("rst_ready", req_ready, 1'b0);
    #5;
    reset_n = 1'b1;
    #1;
    checkOutput("ready_first_clk", req_ready, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("ready_after", req_ready, 1'b1);
    @(negedge clk);

    // Single write: one slot at the first enable edge, then idle
    bus_grant = 1'b1;
    applyStimulus(1'b1, REG_BPLCON0, 16'h9200);
    waitEn();
    @(posedge clk);
    #1;
    checkOutput("single_addr", reg_address_out, 8'h80);
    checkOutput("single_data", data_out, 16'h9200);
    @(negedge clk);
    waitEn();
    @(posedge clk);
    #1;
    checkOutput("single_idle_addr", reg_address_out, 8'hFF);
    checkOutput("single_idle_data", data_out, 16'h0000);
    @(negedge clk);
    waitDrain();

    // Read ordering behind a posted write
    applyStimulus(1'b1, REG_BPLCON0, 16'h0211);
    req_we = 1'b0;
    #1;
    checkOutput("rd_blocked", req_ready, 1'b0);
    applyStimulus(1'b0, REG_DENISEID, 16'h0000);
    #1;
    checkOutput("rd_order", busExp.size(), 1);
    waitDrain();
    checkOutput("rsp_hold", rsp_data, 16'hFFFC);
    @(negedge clk);
    applyStimulus(1'b0, REG_DIWSTRT, 16'h0000);
    waitDrain();
    checkOutput("rsp_hold2", rsp_data, 16'h47B8);
    @(negedge clk);

    // Fill with grant low, then release and count the slots to drain
    bus_grant = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, fillAddr[i], 16'h1000 + 16'(i));
    req_we = 1'b1;
    #1;
    checkOutput("fill_ready", req_ready, 1'b0);
    checkOutput("fill_count", dut.u_fifo.count_q, 8);
    bus_grant = 1'b1;
    applyStimulus(1'b1, fillAddr[8], 16'h1008);
    #1;
    checkOutput("fill_ninth_after_pop", busExp.size(), 8);
    k = 0;
    while (busExp.size() != 0 && k < 20) begin
      @(negedge clk);
      waitEn();
      @(posedge clk);
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("fill_slots", k, 8);
    @(negedge clk);

    // Grant gaps: writes only in granted slots
    bus_grant = 1'b0;
    applyStimulus(1'b1, REG_DIWSTOP, 16'hA001);
    applyStimulus(1'b1, REG_DIWHIGH, 16'hA002);
    applyStimulus(1'b1, REG_BPL1DAT, 16'hA003);
    applyStimulus(1'b1, REG_BPLCON1, 16'hA004);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      waitEn();
      bus_grant = pat[i][0];
      @(posedge clk);
      #1;
      checkOutput("gap_slot", (reg_address_out != 8'hFF), pat[i][0]);
    end
    bus_grant = 1'b1;
    @(negedge clk);
    waitDrain();

    // Simultaneous push/pop at count 4, then random mix across wrap
    bus_grant = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 16'hB000 + 16'(i));
    expCount = 4;
    @(negedge clk);
    waitEn();
    bus_grant = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h20;
    req_data  = 16'hC0DE;
    @(posedge clk);
    busExp.push_back({8'h20, 16'hC0DE});
    #1;
    req_valid = 1'b0;
    checkOutput("simul_count4", dut.u_fifo.count_q, 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      waitEn();
      g = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 3) != 0);
      bus_grant = g;
      req_valid = p;
      req_we    = 1'b1;
      req_addr  = 8'h40 + 8'(i);
      req_data  = 16'($urandom);
      acc       = p && (expCount < 8);
      @(posedge clk);
      if (acc) busExp.push_back({req_addr, req_data});
      expCount = expCount + (acc ? 1 : 0) - ((g && expCount > 0) ? 1 : 0);
      #1;
      req_valid = 1'b0;
      checkOutput("mix_count", dut.u_fifo.count_q, expCount);
    end
    bus_grant = 1'b1;
    @(negedge clk);
    waitDrain();
    @(negedge clk);

    // Asynchronous reset in the middle of a write burst
    bus_grant = 1'b0;
    applyStimulus(1'b1, REG_BPLCON2, 16'hD001);
    applyStimulus(1'b1, REG_BPLCON3, 16'hD002);
    applyStimulus(1'b1, REG_BPLCON4, 16'hD003);
    applyStimulus(1'b1, REG_DIWSTRT, 16'hD004);
    bus_grant = 1'b1;
    n = 0;
    while (reg_address_out == 8'hFF && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_active", (reg_address_out != 8'hFF), 1'b1);
    checkOutput("rst_mid_queued", dut.u_fifo.count_q, 3);
    #5;
    reset_n = 1'b0;
    #1;
    busExp.delete();
    rspExp.delete();
    checkOutput("rst_mid_addr", reg_address_out, 8'hFF);
    checkOutput("rst_mid_data", data_out, 16'h0000);
    checkOutput("rst_mid_count", dut.u_fifo.count_q, 0);
    repeat (3) @(negedge clk);
    #5;
    reset_n = 1'b1;
    req_we  = 1'b1;
    #1;
    checkOutput("rst_mid_ready_first", req_ready, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rst_mid_ready_after", req_ready, 1'b1);
    repeat (24) @(negedge clk);
    checkOutput("rst_mid_no_write", reg_address_out, 8'hFF);

    // Normal operation resumes after reset
    applyStimulus(1'b1, REG_DIWSTOP, 16'hE123);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
